csr_trap_unit: RTL

//  Machine-mode CSR file and trap/interrupt controller; responder side of the EX-stage CSR and trap interface.

---
 rtl/csr_trap_unit_pkg.sv | 71 +++++++
 rtl/csr_trap_unit_if.sv | 37 +++
 rtl/csr_counter64.sv | 24 ++
 rtl/csr_trap_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/csr_trap_unit_pkg.sv
// rtl/csr_trap_unit_pkg.sv - CSR addresses, trap cause codes, bit positions and FSM types
package csr_trap_unit_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // mcause values
  localparam logic [31:0] CAUSE_MEI    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI    = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI    = 32'h8000_0007;
  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;

  // mstatus / mie / mip bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_MSI      = 3;
  localparam int IRQ_MTI      = 7;
  localparam int IRQ_MEI      = 11;

  // MPP is hardwired to machine mode
  localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [31:0] ALIGN4_MASK   = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_PEND,
    IRQ_HOLD
  } irq_state_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_TAKEN,
    EV_ECALL,
    EV_EBREAK,
    EV_MRET
  } trap_event_e;

  // Highest-priority enabled interrupt: external, then software, then timer
  function automatic logic [31:0] irq_cause(input logic [31:0] active);
    if (active[IRQ_MEI])      return CAUSE_MEI;
    else if (active[IRQ_MSI]) return CAUSE_MSI;
    else if (active[IRQ_MTI]) return CAUSE_MTI;
    else                      return 32'h0;
  endfunction

  // mip/mie bit that backs a latched interrupt cause
  function automatic logic [31:0] cause_src_mask(input logic [31:0] cause);
    case (cause)
      CAUSE_MEI: return 32'h0000_0800;
      CAUSE_MSI: return 32'h0000_0008;
      CAUSE_MTI: return 32'h0000_0080;
      default:   return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// rtl/csr_trap_unit_if.sv - EX-stage CSR access and trap reporting interface
interface csr_trap_unit_if;

  logic [11:0] csr_addr;
  logic        csr_read_enable;
  logic [31:0] csr_write_data;
  logic        csr_write_enable;
  logic [31:0] csr_read_data;
  logic        csr_valid;
  logic [31:0] trap_pc;
  logic        interrupt_taken;
  logic        ecall_exception;
  logic        ebreak_exception;
  logic        mret_instruction;
  logic        instr_retired;
  logic        interrupt_pending;
  logic [31:0] interrupt_cause;
  logic [31:0] mtvec;
  logic [31:0] mepc;

  // EX stage side
  modport master (
    output csr_addr, csr_read_enable, csr_write_data, csr_write_enable,
    output trap_pc, interrupt_taken, ecall_exception, ebreak_exception,
    output mret_instruction, instr_retired,
    input  csr_read_data, csr_valid, interrupt_pending, interrupt_cause, mtvec, mepc
  );

  // CSR file / trap controller side
  modport slave (
    input  csr_addr, csr_read_enable, csr_write_data, csr_write_enable,
    input  trap_pc, interrupt_taken, ecall_exception, ebreak_exception,
    input  mret_instruction, instr_retired,
    output csr_read_data, csr_valid, interrupt_pending, interrupt_cause, mtvec, mepc
  );

endinterface

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit wrapping counter with independent lo/hi write ports
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  // A write to either half suppresses the increment for that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 64'd0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wdata;
      if (wr_hi) count[63:32] <= wdata;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode CSR file and trap/interrupt controller
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_irq,
  input  logic             timer_irq,
  input  logic             sw_irq,
  csr_trap_unit_if.slave   bus
);

  logic        mstatus_mie_q;
  logic        mstatus_mpie_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [31:0] cause_q;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic [31:0] mip;
  logic [31:0] mstatus_value;
  logic [31:0] irq_active;
  logic        irq_request;
  logic        source_alive;

  trap_event_e trap_event;
  logic        trap_entry;
  logic [31:0] trap_cause;

  irq_state_e  state_q;
  irq_state_e  state_d;
  logic        latch_cause;

  logic        rd_hit;
  logic [31:0] rd_value;

  logic [11:0] addr;
  logic [31:0] wdata;
  logic        we;

  assign addr  = bus.csr_addr;
  assign wdata = bus.csr_write_data;
  assign we    = bus.csr_write_enable;

  assign mip           = {20'b0, ext_irq, 3'b0, timer_irq, 3'b0, sw_irq, 3'b0};
  assign mstatus_value = MSTATUS_MPP_M | {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign irq_active    = mip & mie_q;
  assign irq_request   = mstatus_mie_q && (|irq_active);
  // A pending interrupt survives only while its own source stays enabled
  assign source_alive  = mstatus_mie_q && (|(irq_active & cause_src_mask(cause_q)));

  // Resolve simultaneous EX events: taken > ecall > ebreak > mret
  always_comb begin
    trap_event = EV_NONE;
    if (bus.interrupt_taken)       trap_event = EV_TAKEN;
    else if (bus.ecall_exception)  trap_event = EV_ECALL;
    else if (bus.ebreak_exception) trap_event = EV_EBREAK;
    else if (bus.mret_instruction) trap_event = EV_MRET;
  end

  assign trap_entry = (trap_event == EV_TAKEN) || (trap_event == EV_ECALL) ||
                      (trap_event == EV_EBREAK);

  // mcause value written on trap entry
  always_comb begin
    trap_cause = 32'h0;
    case (trap_event)
      EV_TAKEN:  trap_cause = cause_q;
      EV_ECALL:  trap_cause = CAUSE_ECALL;
      EV_EBREAK: trap_cause = CAUSE_EBREAK;
      default:   trap_cause = 32'h0;
    endcase
  end

  // mstatus: trap entry and mret take precedence over a software write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
    end else if (trap_entry) begin
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (trap_event == EV_MRET) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (we && addr == CSR_MSTATUS) begin
      mstatus_mie_q  <= wdata[MSTATUS_MIE];
      mstatus_mpie_q <= wdata[MSTATUS_MPIE];
    end
  end

  // Trap state registers: hardware trap entry wins over software writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc_q   <= 32'h0;
      mcause_q <= 32'h0;
      mtval_q  <= 32'h0;
    end else if (trap_entry) begin
      mepc_q   <= bus.trap_pc & ALIGN4_MASK;
      mcause_q <= trap_cause;
      mtval_q  <= 32'h0;
    end else if (we) begin
      if (addr == CSR_MEPC)   mepc_q   <= wdata & ALIGN4_MASK;
      if (addr == CSR_MCAUSE) mcause_q <= wdata;
      if (addr == CSR_MTVAL)  mtval_q  <= wdata;
    end
  end

  // Plain software-writable CSRs, unaffected by traps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= 32'h0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= 32'h0;
    end else if (we) begin
      if (addr == CSR_MIE)      mie_q      <= wdata & MIE_WMASK;
      if (addr == CSR_MTVEC)    mtvec_q    <= wdata & ALIGN4_MASK;
      if (addr == CSR_MSCRATCH) mscratch_q <= wdata;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (we && addr == CSR_MCYCLE),
    .wr_hi (we && addr == CSR_MCYCLEH),
    .wdata (wdata),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.instr_retired),
    .wr_lo (we && addr == CSR_MINSTRET),
    .wr_hi (we && addr == CSR_MINSTRETH),
    .wdata (wdata),
    .count (minstret)
  );

  // Interrupt FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IRQ_IDLE;
    else        state_q <= state_d;
  end

  // Interrupt FSM next state; HOLD masks the request while EX flushes
  always_comb begin
    state_d     = state_q;
    latch_cause = 1'b0;
    case (state_q)
      IRQ_IDLE: begin
        if (trap_event != EV_NONE) begin
          state_d = IRQ_HOLD;
        end else if (irq_request) begin
          state_d     = IRQ_PEND;
          latch_cause = 1'b1;
        end
      end
      IRQ_PEND: begin
        if (trap_event != EV_NONE) state_d = IRQ_HOLD;
        else if (!source_alive)    state_d = IRQ_IDLE;
      end
      IRQ_HOLD: state_d = IRQ_IDLE;
      default:  state_d = IRQ_IDLE;
    endcase
  end

  // Cause is frozen at the IDLE->PEND decision so EX sees a stable value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cause_q <= 32'h0;
    else if (latch_cause) cause_q <= irq_cause(irq_active);
  end

  // Combinational CSR read mux
  always_comb begin
    rd_hit   = 1'b1;
    rd_value = 32'h0;
    case (addr)
      CSR_MSTATUS:   rd_value = mstatus_value;
      CSR_MISA:      rd_value = MISA_VALUE;
      CSR_MIE:       rd_value = mie_q;
      CSR_MTVEC:     rd_value = mtvec_q;
      CSR_MSCRATCH:  rd_value = mscratch_q;
      CSR_MEPC:      rd_value = mepc_q;
      CSR_MCAUSE:    rd_value = mcause_q;
      CSR_MTVAL:     rd_value = mtval_q;
      CSR_MIP:       rd_value = mip;
      CSR_MCYCLE:    rd_value = mcycle[31:0];
      CSR_MCYCLEH:   rd_value = mcycle[63:32];
      CSR_MINSTRET:  rd_value = minstret[31:0];
      CSR_MINSTRETH: rd_value = minstret[63:32];
      CSR_MHARTID:   rd_value = HART_ID;
      default:       rd_hit   = 1'b0;
    endcase
  end

  assign bus.csr_read_data     = rd_value;
  assign bus.csr_valid         = bus.csr_read_enable && rd_hit;
  assign bus.interrupt_pending = (state_q == IRQ_PEND);
  assign bus.interrupt_cause   = cause_q;
  assign bus.mtvec             = mtvec_q;
  assign bus.mepc              = mepc_q;

endmodule
